// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine with the HI/LO register pair.
// One operation takes WIDTH iterations in CALC followed by a single FIX cycle,
// in which the sign correction is applied and HI/LO are written.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);
  localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Absolute value of an operand; only negative values of a signed op are flipped.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = ~v + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's complement negation of a WIDTH-bit value when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      cond_neg_w = ~v + ONE_W;
    end else begin
      cond_neg_w = v;
    end
  endfunction

  // Two's complement negation of a 2*WIDTH-bit value when neg is set.
  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    if (neg) begin
      cond_neg_2w = ~v + ONE_2W;
    end else begin
      cond_neg_2w = v;
    end
  endfunction

  state_t               state_q,    state_d;
  logic [CW-1:0]        count_q,    count_d;
  logic [2*WIDTH-1:0]   acc_q,      acc_d;       // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q,     opnd_d;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]     a_raw_q,    a_raw_d;     // raw dividend, returned in HI on divide-by-zero
  logic                 is_div_q,   is_div_d;
  logic                 neg_res_q,  neg_res_d;   // product/quotient must be negated
  logic                 neg_rem_q,  neg_rem_d;   // remainder must be negated
  logic                 dz_q,       dz_d;        // divisor was zero at accept
  logic [WIDTH-1:0]     hi_q,       hi_d;
  logic [WIDTH-1:0]     lo_q,       lo_d;
  logic                 done_q,     done_d;
  logic                 div_zero_q, div_zero_d;

  // Datapath for one iteration and the final sign correction.
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic                 signed_op_s;

  assign signed_op_s = ~op[0];

  // Shift-add: add multiplicand to the upper half when the current multiplier bit is set, then shift right.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and try subtracting the divisor.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
  assign div_next_s  = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix_s = cond_neg_2w(acc_q, neg_res_q);
  assign quo_fix_s  = cond_neg_w(acc_q[WIDTH-1:0], neg_res_q);
  assign rem_fix_s  = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

  // Next-state, iteration and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Accept: latch everything the operation needs; moves to HI/LO are dropped.
          state_d   = S_CALC;
          count_d   = {CW{1'b0}};
          is_div_d  = op[1];
          neg_res_d = signed_op_s & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          neg_rem_d = signed_op_s & operand_a[WIDTH-1];
          dz_d      = op[1] & (operand_b == ZERO_W);
          a_raw_d   = operand_a;
          if (op[1]) begin
            acc_d  = {ZERO_W, magnitude(operand_a, signed_op_s)};
            opnd_d = magnitude(operand_b, signed_op_s);
          end else begin
            acc_d  = {ZERO_W, magnitude(operand_b, signed_op_s)};
            opnd_d = magnitude(operand_a, signed_op_s);
          end
        end else begin
          if (mthi) begin
            hi_d = operand_a;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = operand_a;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = div_next_s;
        end else begin
          acc_d = mul_next_s;
        end
        if (count_q == CNT_LAST) begin
          state_d = S_FIX;
          count_d = {CW{1'b0}};
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (dz_q) begin
            hi_d       = a_raw_q;
            lo_d       = ONES_W;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= {CW{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opnd_q     <= ZERO_W;
      a_raw_q    <= ZERO_W;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign rd_data  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Testbench for hilo_muldiv_unit: directed cases plus random ops against a 64-bit arithmetic model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, mthi, mtlo, rd_sel;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic [W-1:0] rd_data;
  logic         busy, done, div_zero;

  int tests  = 0;
  int failed = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic. SV division truncates toward zero and the
  // remainder follows the dividend's sign, which is exactly the required behaviour.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      default: begin
        if (b == 32'd0) begin
          p  = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {(ua % ub) << 32} | (ua / ub);
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    rd_sel = 1'b0; #1; lo = rd_data;
    rd_sel = 1'b1; #1; hi = rd_data;
    rd_sel = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Issue one op at the current negedge; returns the observed HI/LO/div_zero at done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [31:0] ehi, elo, old_hi, old_lo, bh, bl;
    logic edz;
    int lat;
    model(o, a, b, ehi, elo, edz);
    read_hilo(old_hi, old_lo);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    read_hilo(bh, bl);
    check({tag, "_rd_busy"}, {bh, bl}, {old_hi, old_lo});
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    dz = div_zero;
    read_hilo(hi, lo);
    check({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    check({tag, "_dz"}, 64'(dz), 64'(edz));
  endtask

  task automatic directed(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag,
                          input logic [31:0] xhi, input logic [31:0] xlo, input logic xdz);
    logic [31:0] hi, lo;
    logic dz;
    run_op(o, a, b, tag, hi, lo, dz);
    check({tag, "_const"}, {31'd0, dz, hi, lo}, {31'd0, xdz, xhi, xlo});
  endtask

  initial begin
    logic [31:0] hi, lo, ra, rb;
    logic dz;
    logic [1:0] ro;
    int n, first;

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_sel = 1'b0;
    op = 2'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    read_hilo(hi, lo);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases, issued back to back (each start lands in the previous done cycle).
    directed(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    directed(2'b00, 32'hFFFF_FFFD, 32'd7,         "mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    directed(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minsq", 32'h4000_0000, 32'h0, 1'b0);
    directed(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    directed(2'b11, 32'd100,       32'd7,         "divu_100d7", 32'd2, 32'hE, 1'b0);
    directed(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'd0, 32'h8000_0000, 1'b0);
    directed(2'b11, 32'd5,         32'd0,         "divu_by0", 32'd5, 32'hFFFF_FFFF, 1'b1);
    directed(2'b01, 32'd3,         32'd5,         "after_dz", 32'd0, 32'd15, 1'b0);
    @(negedge clock);
    check("done_pulse_len", 64'(done), 64'd0);
    check("dz_pulse_len", 64'(div_zero), 64'd0);

    // A second start during CALC is ignored: exactly one done, first op's result.
    start = 1'b1; op = 2'b01; operand_a = 32'd6; operand_b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n = 0; first = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (i == 4) begin
        start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd3;
      end
      if (i == 5) start = 1'b0;
      if (done === 1'b1) begin
        n++;
        if (first == 0) first = i;
      end
    end
    check("ignore_done_cnt", 64'(n), 64'd1);
    check("ignore_lat", 64'(first), 64'd33);
    read_hilo(hi, lo);
    check("ignore_result", {hi, lo}, {32'd0, 32'd42});

    // mthi in IDLE, mthi+mtlo together.
    mthi = 1'b1; operand_a = 32'h0000_1234;
    @(posedge clock); @(negedge clock);
    mthi = 1'b0;
    read_hilo(hi, lo);
    check("mthi_idle", {hi, lo}, {32'h1234, 32'd42});
    mthi = 1'b1; mtlo = 1'b1; operand_a = 32'hCAFE_F00D;
    @(posedge clock); @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    read_hilo(hi, lo);
    check("mthi_mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    mthi = 1'b1; operand_a = 32'h0000_1234;
    @(posedge clock); @(negedge clock);
    mthi = 1'b0;

    // mthi while busy: HI untouched during the op, then takes the product.
    start = 1'b1; op = 2'b01; operand_a = 32'h0001_0000; operand_b = 32'h0003_0000;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    mthi = 1'b1; operand_a = 32'hDEAD_BEEF;
    @(negedge clock);
    mthi = 1'b0;
    read_hilo(hi, lo);
    check("mthi_busy_hold", 64'(hi), 64'h1234);
    wait_done(n);
    read_hilo(hi, lo);
    check("mthi_busy_result", {hi, lo}, {32'd3, 32'd0});

    // start together with mtlo: start wins.
    start = 1'b1; mtlo = 1'b1; op = 2'b01; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clock); @(negedge clock);
    start = 1'b0; mtlo = 1'b0;
    wait_done(n);
    read_hilo(hi, lo);
    check("start_mtlo", {hi, lo}, {32'd0, 32'd15});

    // Reset during CALC aborts: no done, HI/LO cleared.
    @(negedge clock);
    start = 1'b1; op = 2'b01; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    read_hilo(hi, lo);
    check("abort_hilo", {hi, lo}, 64'd0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done === 1'b1) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);

    // Random ops against the model.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, $sformatf("rnd%0d", k), hi, lo, dz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
